// File: rtl/alu_op_sequencer.sv
// Command/response sequencer around an 8-bit combinational ALU.
// Optional accumulator enabled by defining ALU_OP_SEQUENCER_ACC_EN.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_op_i,
    input  logic [7:0] cmd_a_i,
    input  logic [7:0] cmd_b_i,
    input  logic       cmd_acc_i,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic [2:0] alu_op_o,
    input  logic [7:0] alu_res_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       rsp_zero_o,
    output logic [7:0] acc_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] a_sel;
    logic       sample;

    assign sample = (state == WAIT) && (cnt == 4'd0);

`ifdef ALU_OP_SEQUENCER_ACC_EN
    logic [7:0] acc_q;

    assign acc_o = acc_q;
    assign a_sel = cmd_acc_i ? acc_q : cmd_a_i;

    // Every completed command refreshes the accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= 8'h00;
        end else if (sample) begin
            acc_q <= alu_res_i;
        end
    end
`else
    logic unused_acc;

    assign unused_acc = cmd_acc_i;
    assign acc_o      = 8'h00;
    assign a_sel      = cmd_a_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cmd_ready_o <= 1'b0;
            alu_a_o     <= 8'h00;
            alu_b_o     <= 8'h00;
            alu_op_o    <= 3'd0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 8'h00;
            rsp_zero_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        alu_op_o    <= cmd_op_i;
                        alu_b_o     <= cmd_b_i;
                        alu_a_o     <= a_sel;
                        cnt         <= LOAD;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (sample) begin
                        rsp_data_o  <= alu_res_i;
                        rsp_zero_o  <= (alu_res_i == 8'h00);
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model.
// Two instances: SETTLE_CYCLES=1 and SETTLE_CYCLES=4.
module tb_alu_op_sequencer;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    logic       cmd_valid, cmd_ready, cmd_acc;
    logic [2:0] cmd_op, alu_op;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_res;
    logic       rsp_valid, rsp_ready, rsp_zero, busy;
    logic [7:0] rsp_data, acc;

    logic       cmd_valid_4, cmd_ready_4, cmd_acc_4;
    logic [2:0] cmd_op_4, alu_op_4;
    logic [7:0] cmd_a_4, cmd_b_4, alu_a_4, alu_b_4, alu_res_4;
    logic       rsp_valid_4, rsp_ready_4, rsp_zero_4, busy_4;
    logic [7:0] rsp_data_4, acc_4;

    function automatic logic [7:0] alu(logic [2:0] op, logic [7:0] a,
                                       logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << b[2:0];
            3'd3:    return a >> b[2:0];
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    assign alu_res   = alu(alu_op, alu_a, alu_b);
    assign alu_res_4 = alu(alu_op_4, alu_a_4, alu_b_4);

    alu_op_sequencer #(.SETTLE_CYCLES(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .cmd_acc_i(cmd_acc),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_res_i(alu_res),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero),
        .acc_o(acc), .busy_o(busy)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(4)) u4 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_4), .cmd_ready_o(cmd_ready_4),
        .cmd_op_i(cmd_op_4), .cmd_a_i(cmd_a_4), .cmd_b_i(cmd_b_4),
        .cmd_acc_i(cmd_acc_4),
        .alu_a_o(alu_a_4), .alu_b_o(alu_b_4), .alu_op_o(alu_op_4),
        .alu_res_i(alu_res_4),
        .rsp_valid_o(rsp_valid_4), .rsp_ready_i(rsp_ready_4),
        .rsp_data_o(rsp_data_4), .rsp_zero_o(rsp_zero_4),
        .acc_o(acc_4), .busy_o(busy_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic use_acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = use_acc;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_acc = 0;
        rsp_ready = 0;
        cmd_valid_4 = 0; cmd_op_4 = 0; cmd_a_4 = 0; cmd_b_4 = 0;
        cmd_acc_4 = 0; rsp_ready_4 = 0;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_acc", acc, 0);
        end
        rst_n = 1'b1;
        cyc();
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_cmd_ready_4", cmd_ready_4, 1);

        // Add 0x0F + 0x01
        send(3'd0, 8'h0F, 8'h01, 1'b0);
        cyc();
        cmd_valid = 0;
        chk("add_alu_op", alu_op, 3'd0);
        chk("add_alu_a", alu_a, 8'h0F);
        chk("add_alu_b", alu_b, 8'h01);
        chk("add_cmd_ready", cmd_ready, 0);
        chk("add_busy", busy, 1);
        chk("add_valid_early", rsp_valid, 0);
        cyc();
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_rsp_data", rsp_data, 8'h10);
        chk("add_rsp_zero", rsp_zero, 0);
`ifdef ALU_OP_SEQUENCER_ACC_EN
        chk("add_acc", acc, 8'h10);
`else
        chk("add_acc", acc, 8'h00);
`endif
        rsp_ready = 1;
        cyc();
        chk("add_hs_valid", rsp_valid, 0);
        chk("add_hs_ready", cmd_ready, 1);
        chk("add_hs_busy", busy, 0);

        // Sub to zero, rsp_ready already high
        send(3'd1, 8'h2A, 8'h2A, 1'b0);
        cyc();
        cmd_valid = 0;
        cyc();
        chk("sub_rsp_valid", rsp_valid, 1);
        chk("sub_rsp_data", rsp_data, 8'h00);
        chk("sub_rsp_zero", rsp_zero, 1);
        cyc();
        chk("sub_hs_valid", rsp_valid, 0);
        chk("sub_hs_ready", cmd_ready, 1);

        // Compare equal
        send(3'd7, 8'h2A, 8'h2A, 1'b0);
        cyc();
        cmd_valid = 0;
        chk("eq_alu_op", alu_op, 3'd7);
        cyc();
        chk("eq_rsp_data", rsp_data, 8'h01);
        chk("eq_rsp_zero", rsp_zero, 0);
        cyc();

        // Xor
        send(3'd6, 8'hA5, 8'hFF, 1'b0);
        cyc();
        cmd_valid = 0;
        cyc();
        chk("xor_rsp_data", rsp_data, 8'h5A);
        cyc();

        // Backpressure with a pending second command
        rsp_ready = 0;
        send(3'd4, 8'hF0, 8'h3C, 1'b0);
        cyc();
        send(3'd5, 8'h01, 8'h02, 1'b0);
        cyc();
        chk("bp_rsp_data", rsp_data, 8'h30);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_data", rsp_data, 8'h30);
            chk("bp_hold_ready", cmd_ready, 0);
            chk("bp_hold_alu_a", alu_a, 8'hF0);
            chk("bp_hold_alu_b", alu_b, 8'h3C);
            chk("bp_hold_alu_op", alu_op, 3'd4);
        end
        rsp_ready = 1;
        cyc();
        chk("bp_hs_valid", rsp_valid, 0);
        chk("bp_hs_ready", cmd_ready, 1);
        chk("bp_hs_alu_a", alu_a, 8'hF0);
        cyc();
        cmd_valid = 0;
        chk("bp_second_alu_a", alu_a, 8'h01);
        chk("bp_second_alu_op", alu_op, 3'd5);
        cyc();
        chk("bp_second_data", rsp_data, 8'h03);
        cyc();

        // Accumulator chain
        send(3'd0, 8'h05, 8'h03, 1'b0);
        cyc();
        cmd_valid = 0;
        cyc();
        chk("acc1_rsp_data", rsp_data, 8'h08);
        cyc();
        send(3'd1, 8'hFF, 8'h02, 1'b1);
        cyc();
        cmd_valid = 0;
        cmd_acc = 0;
`ifdef ALU_OP_SEQUENCER_ACC_EN
        chk("acc2_alu_a", alu_a, 8'h08);
        cyc();
        chk("acc2_rsp_data", rsp_data, 8'h06);
        chk("acc2_acc", acc, 8'h06);
`else
        chk("acc2_alu_a", alu_a, 8'hFF);
        cyc();
        chk("acc2_rsp_data", rsp_data, 8'hFD);
        chk("acc2_acc", acc, 8'h00);
`endif
        cyc();

        // SETTLE_CYCLES=4: full command timing
        rsp_ready_4 = 1;
        cmd_valid_4 = 1; cmd_op_4 = 3'd0; cmd_a_4 = 8'h03; cmd_b_4 = 8'h04;
        cyc();
        cmd_valid_4 = 0;
        chk("s4_busy", busy_4, 1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("s4_valid_early", rsp_valid_4, 0);
        end
        cyc();
        chk("s4_rsp_valid", rsp_valid_4, 1);
        chk("s4_rsp_data", rsp_data_4, 8'h07);
        cyc();
        chk("s4_hs_ready", cmd_ready_4, 1);

        // Reset two cycles after accept
        rsp_ready_4 = 0;
        cmd_valid_4 = 1; cmd_op_4 = 3'd6; cmd_a_4 = 8'h0F; cmd_b_4 = 8'hF0;
        cyc();
        cmd_valid_4 = 0;
        chk("mid_busy", busy_4, 1);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_busy_now", busy_4, 0);
        chk("mid_acc", acc_4, 0);
        chk("mid_alu_a", alu_a_4, 0);
        chk("mid_cmd_ready", cmd_ready_4, 0);
        chk("mid_rsp_valid", rsp_valid_4, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("mid_no_rsp", rsp_valid_4, 0);
            chk("mid_no_busy", busy_4, 0);
        end
        chk("mid_ready_after", cmd_ready_4, 1);
        chk("mid_acc_after", acc_4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
